// File: rtl/beat_gen.sv
// beat_gen: instruction beat sequencer.
// Walks each instruction through SCAN1 -> SCAN2 -> ACTION beats of
// DIGITS_PER_BEAT digit periods (one clk per digit), the last
// DIGITS_PER_BEAT-WORD_BITS digits of every beat being blackout.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   run               : continuous-run level switch
//   single_shot       : pulse, executes one instruction while stopped
//   stop_req          : stop-instruction decode, sampled during ACTION
//   beat[1:0]         : 0 SCAN1, 1 SCAN2, 2 ACTION, 3 STOPPED
//   digit[5:0]        : digit within beat
//   ha                : action gate (ACTION, data digits)
//   blackout          : blackout digits of any running beat
//   lstat_strobe      : load L staticiser (last digit of SCAN2)
//   ci_inc            : control-instruction increment (SCAN1 digit 0)
//   running           : beat != STOPPED
module beat_gen #(
  parameter int unsigned WORD_BITS       = 32,
  parameter int unsigned DIGITS_PER_BEAT = 36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       single_shot,
  input  logic       stop_req,
  output logic [1:0] beat,
  output logic [5:0] digit,
  output logic       ha,
  output logic       blackout,
  output logic       lstat_strobe,
  output logic       ci_inc,
  output logic       running
);

  typedef enum logic [1:0] {
    SCAN1   = 2'd0,
    SCAN2   = 2'd1,
    ACTION  = 2'd2,
    STOPPED = 2'd3
  } beat_e;

  localparam logic [5:0] LAST_DIGIT = 6'(DIGITS_PER_BEAT - 1);
  localparam logic [5:0] WORD_END   = 6'(WORD_BITS);

  beat_e      beat_q, beat_d;
  logic [5:0] digit_q, digit_d;
  logic       stop_q, stop_d;   // stop latch
  logic       ss_q, ss_d;       // single-shot in progress
  logic       run_q;            // registered run for edge detection
  logic       beat_end;

  assign beat_end = (digit_q == LAST_DIGIT);

  always_comb begin
    beat_d  = beat_q;
    digit_d = digit_q;
    stop_d  = stop_q;
    ss_d    = ss_q;

    if (beat_q != STOPPED) begin
      digit_d = beat_end ? '0 : digit_q + 6'd1;
    end

    case (beat_q)
      STOPPED: begin
        digit_d = '0;
        stop_d  = 1'b0;
        ss_d    = 1'b0;
        if (run && !run_q) begin
          beat_d = SCAN1;
        end else if (single_shot && !run) begin
          beat_d = SCAN1;
          ss_d   = 1'b1;
        end
      end
      SCAN1: begin
        if (beat_end) beat_d = SCAN2;
      end
      SCAN2: begin
        if (beat_end) beat_d = ACTION;
      end
      ACTION: begin
        if (stop_req) stop_d = 1'b1;
        if (beat_end) begin
          // stop_req on the final digit must stop this instruction too,
          // so the live request is folded into the decision.
          if (run && !stop_q && !stop_req && !ss_q) begin
            beat_d = SCAN1;
          end else begin
            beat_d = STOPPED;
            stop_d = 1'b0;
            ss_d   = 1'b0;
          end
        end
      end
      default: begin
        beat_d  = STOPPED;
        digit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= STOPPED;
      digit_q <= '0;
      stop_q  <= 1'b0;
      ss_q    <= 1'b0;
      run_q   <= 1'b1;  // run held high through reset must not look like an edge
    end else begin
      beat_q  <= beat_d;
      digit_q <= digit_d;
      stop_q  <= stop_d;
      ss_q    <= ss_d;
      run_q   <= run;
    end
  end

  assign beat         = beat_q;
  assign digit        = digit_q;
  assign running      = (beat_q != STOPPED);
  assign ha           = (beat_q == ACTION) && (digit_q < WORD_END);
  assign blackout     = running && (digit_q >= WORD_END);
  assign ci_inc       = (beat_q == SCAN1) && (digit_q == 6'd0);
  assign lstat_strobe = (beat_q == SCAN2) && beat_end;

endmodule

// File: tb/tb_beat_gen.sv
module tb_beat_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       single_shot = 1'b0;
  logic       stop_req = 1'b0;
  logic [1:0] beat;
  logic [5:0] digit;
  logic       ha, blackout, lstat_strobe, ci_inc, running;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  beat_gen #(.WORD_BITS(32), .DIGITS_PER_BEAT(36)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .single_shot  (single_shot),
    .stop_req     (stop_req),
    .beat         (beat),
    .digit        (digit),
    .ha           (ha),
    .blackout     (blackout),
    .lstat_strobe (lstat_strobe),
    .ci_inc       (ci_inc),
    .running      (running)
  );

  // advance one clk and settle; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    tick(); tick();
    checks++;
    if ({beat, digit, ha, blackout, lstat_strobe, ci_inc, running} !== {2'd3, 6'd0, 5'b0}) begin
      errors++;
      $display("FAIL reset_state: beat=%0d digit=%0d ha=%b bo=%b ls=%b ci=%b run=%b, need beat=3 digit=0 all 0",
               beat, digit, ha, blackout, lstat_strobe, ci_inc, running);
    end
    rst = 1'b0; tick(); tick();
    checks++;
    if (beat !== 2'd3) begin
      errors++;
      $display("FAIL reset_release_run_high: beat=%0d need 3", beat);
    end
  endtask

  task automatic test_run_timing();
    int ci_at = -1, ls_at = -1, ha_first = -1, ha_last = -1;
    int ha_cnt = 0, bo_cnt = 0, overlap = 0;
    run = 1'b0; tick(); tick();
    run = 1'b1; tick();
    for (int c = 1; c <= 108; c++) begin
      if (ci_inc && ci_at < 0) ci_at = c;
      if (lstat_strobe && ls_at < 0) ls_at = c;
      if (ha) begin
        if (ha_first < 0) ha_first = c;
        ha_last = c;
        ha_cnt++;
      end
      if (blackout) bo_cnt++;
      if (ha && blackout) overlap++;
      tick();
    end
    checks++;
    if (ci_at !== 1) begin errors++; $display("FAIL ci_inc_cycle: got %0d need 1", ci_at); end
    checks++;
    if (ls_at !== 72) begin errors++; $display("FAIL lstat_cycle: got %0d need 72", ls_at); end
    checks++;
    if (ha_first !== 73 || ha_last !== 104 || ha_cnt !== 32) begin
      errors++;
      $display("FAIL ha_window: got %0d..%0d cnt %0d need 73..104 cnt 32", ha_first, ha_last, ha_cnt);
    end
    checks++;
    if (bo_cnt !== 12 || overlap !== 0) begin
      errors++;
      $display("FAIL blackout_count: got %0d overlap %0d need 12 overlap 0", bo_cnt, overlap);
    end
    // now at cycle 109
    checks++;
    if (beat !== 2'd0 || digit !== 6'd0 || ci_inc !== 1'b1) begin
      errors++;
      $display("FAIL period_109: beat=%0d digit=%0d ci=%b need 0 0 1", beat, digit, ci_inc);
    end
  endtask

  task automatic test_stop();
    int n = 0;
    int ci_cnt = 0, moved = 0;
    while (!(beat == 2'd2 && digit == 6'd5) && n < 200) begin tick(); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL stop_reach_action5: timeout beat=%0d digit=%0d", beat, digit); end
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    for (int i = 0; i < 29; i++) tick();
    checks++;
    if (beat !== 2'd2 || digit !== 6'd35) begin
      errors++;
      $display("FAIL stop_last_action: beat=%0d digit=%0d need 2 35", beat, digit);
    end
    tick();
    checks++;
    if (beat !== 2'd3 || running !== 1'b0 || digit !== 6'd0) begin
      errors++;
      $display("FAIL stop_stopped: beat=%0d running=%b digit=%0d need 3 0 0", beat, running, digit);
    end
    for (int i = 0; i < 150; i++) begin
      if (ci_inc) ci_cnt++;
      if (beat !== 2'd3) moved++;
      tick();
    end
    checks++;
    if (ci_cnt !== 0 || moved !== 0) begin
      errors++;
      $display("FAIL stop_no_restart: ci=%0d moved=%0d need 0 0", ci_cnt, moved);
    end
  endtask

  task automatic test_single_shot();
    int ci_cnt = 0, ls_cnt = 0, ha_cnt = 0;
    logic [1:0] b109 = 2'd0;
    run = 1'b0; tick(); tick();
    single_shot = 1'b1; tick();
    for (int c = 1; c <= 120; c++) begin
      if (ci_inc) ci_cnt++;
      if (lstat_strobe) ls_cnt++;
      if (ha) ha_cnt++;
      if (c == 109) b109 = beat;
      single_shot = (c == 47);
      tick();
    end
    checks++;
    if (ci_cnt !== 1 || ls_cnt !== 1 || ha_cnt !== 32) begin
      errors++;
      $display("FAIL single_shot_counts: ci=%0d ls=%0d ha=%0d need 1 1 32", ci_cnt, ls_cnt, ha_cnt);
    end
    checks++;
    if (b109 !== 2'd3 || beat !== 2'd3) begin
      errors++;
      $display("FAIL single_shot_stop: beat109=%0d beat_end=%0d need 3 3", b109, beat);
    end
  endtask

  task automatic test_run_drop();
    int ci_cnt = 0;
    logic [1:0] b108 = 2'd0, b216 = 2'd0, b217 = 2'd0;
    logic [5:0] d216 = 6'd0;
    run = 1'b1; tick();
    for (int c = 1; c <= 230; c++) begin
      if (ci_inc) ci_cnt++;
      if (c == 109) b108 = beat;
      if (c == 216) begin b216 = beat; d216 = digit; end
      if (c == 217) b217 = beat;
      if (c == 155) run = 1'b0;
      tick();
    end
    checks++;
    if (b108 !== 2'd0 || ci_cnt !== 2) begin
      errors++;
      $display("FAIL run_drop_second_instr: beat109=%0d ci=%0d need 0 2", b108, ci_cnt);
    end
    checks++;
    if (b216 !== 2'd2 || d216 !== 6'd35 || b217 !== 2'd3) begin
      errors++;
      $display("FAIL run_drop_complete: b216=%0d d216=%0d b217=%0d need 2 35 3", b216, d216, b217);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0, moved = 0, n = 0;
    run = 1'b0; tick();
    run = 1'b1; tick();
    for (int c = 1; c < 93; c++) tick();
    checks++;
    if (beat !== 2'd2 || digit !== 6'd20) begin
      errors++;
      $display("FAIL rst_mid_position: beat=%0d digit=%0d need 2 20", beat, digit);
    end
    rst = 1'b1; tick();
    checks++;
    if (beat !== 2'd3 || ha !== 1'b0 || digit !== 6'd0 || ci_inc !== 1'b0 || lstat_strobe !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_abort: beat=%0d ha=%b digit=%0d ci=%b ls=%b need 3 0 0 0 0",
               beat, ha, digit, ci_inc, lstat_strobe);
    end
    tick(); rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (ci_inc || lstat_strobe) pulses++;
      if (beat !== 2'd3) moved++;
      tick();
    end
    checks++;
    if (pulses !== 0 || moved !== 0) begin
      errors++;
      $display("FAIL rst_mid_hold: pulses=%0d moved=%0d need 0 0", pulses, moved);
    end
    run = 1'b0; tick();
    run = 1'b1;
    while (!ci_inc && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 1 || beat !== 2'd0 || digit !== 6'd0) begin
      errors++;
      $display("FAIL rst_mid_restart: cycles=%0d beat=%0d digit=%0d need 1 0 0", n, beat, digit);
    end
  endtask

  initial begin
    test_reset();
    test_run_timing();
    test_stop();
    test_single_shot();
    test_run_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
